// File: rtl/branch_predictor.sv
// Dynamic branch predictor: PHT of saturating counters (bimodal or gshare)
// plus a direct-mapped BTB, trained from decode with speculative GHR repair.
module branch_predictor #(
   parameter int unsigned PHT_LOG2 = 10,
   parameter int unsigned GHR_W    = 8,
   parameter int unsigned CTR_W    = 2,
   parameter int unsigned BTB_LOG2 = 6,
   parameter int unsigned MODE     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      pcF,
   input  logic             stallF,
   output logic             pred_takenF,
   output logic [31:0]      pred_targetF,
   output logic [GHR_W-1:0] ghr_snapF,
   input  logic             upd_enD,
   input  logic [31:0]      upd_pcD,
   input  logic             upd_takenD,
   input  logic [31:0]      upd_targetD,
   input  logic             upd_pred_takenD,
   input  logic [31:0]      upd_pred_targetD,
   input  logic [GHR_W-1:0] upd_ghrD,
   output logic             mispredictD,
   output logic [31:0]      redirect_pcD
);

   localparam int unsigned PHT_N = 1 << PHT_LOG2;
   localparam int unsigned BTB_N = 1 << BTB_LOG2;
   localparam int unsigned TAG_W = 32 - BTB_LOG2 - 2;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

   logic [CTR_W-1:0] pht        [PHT_N];
   logic             btb_valid  [BTB_N];
   logic [TAG_W-1:0] btb_tag    [BTB_N];
   logic [31:0]      btb_target [BTB_N];
   logic [GHR_W-1:0] ghr;

   logic [PHT_LOG2-1:0] f_pht_idx;
   logic [BTB_LOG2-1:0] f_btb_idx;
   logic                f_hit;
   logic [PHT_LOG2-1:0] u_pht_idx;
   logic [BTB_LOG2-1:0] u_btb_idx;
   logic [CTR_W-1:0]    u_ctr;
   logic [CTR_W-1:0]    u_ctr_next;
   logic [GHR_W-1:0]    ghr_next;

   // Fetch-side lookup: index/tag compare and direction/target prediction
   always_comb begin
      f_pht_idx = pcF[PHT_LOG2+1:2];
      if (MODE == 1) begin
         f_pht_idx = pcF[PHT_LOG2+1:2] ^ PHT_LOG2'(ghr);
      end
      f_btb_idx    = pcF[BTB_LOG2+1:2];
      f_hit        = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == pcF[31:BTB_LOG2+2]);
      pred_takenF  = f_hit & pht[f_pht_idx][CTR_W-1];
      pred_targetF = pred_takenF ? btb_target[f_btb_idx] : pcF + 32'd4;
      ghr_snapF    = ghr;
   end

   // Decode-side resolution: mispredict detection, redirect and counter step
   always_comb begin
      u_pht_idx = upd_pcD[PHT_LOG2+1:2];
      if (MODE == 1) begin
         u_pht_idx = upd_pcD[PHT_LOG2+1:2] ^ PHT_LOG2'(upd_ghrD);
      end
      u_btb_idx   = upd_pcD[BTB_LOG2+1:2];
      u_ctr       = pht[u_pht_idx];
      u_ctr_next  = u_ctr;
      if (upd_takenD) begin
         if (u_ctr != CTR_MAX) u_ctr_next = u_ctr + CTR_ONE;
      end else begin
         if (u_ctr != '0) u_ctr_next = u_ctr - CTR_ONE;
      end
      mispredictD  = upd_enD & ((upd_pred_takenD != upd_takenD) |
                                (upd_takenD & (upd_pred_targetD != upd_targetD)));
      redirect_pcD = upd_takenD ? upd_targetD : upd_pcD + 32'd4;
   end

   // Next GHR: mispredict repair beats the speculative fetch shift
   always_comb begin
      ghr_next = ghr;
      if (mispredictD) begin
         ghr_next = {upd_ghrD[GHR_W-2:0], upd_takenD};
      end else if (!stallF && f_hit) begin
         ghr_next = {ghr[GHR_W-2:0], pred_takenF};
      end
   end

   // Predictor state: GHR, PHT counters and BTB entries
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr <= '0;
         for (int i = 0; i < int'(PHT_N); i++) begin
            pht[i] <= CTR_INIT;
         end
         for (int i = 0; i < int'(BTB_N); i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
         end
      end else begin
         ghr <= ghr_next;
         if (upd_enD) begin
            pht[u_pht_idx] <= u_ctr_next;
            if (upd_takenD) begin
               btb_valid[u_btb_idx]  <= 1'b1;
               btb_tag[u_btb_idx]    <= upd_pcD[31:BTB_LOG2+2];
               btb_target[u_btb_idx] <= upd_targetD;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: bimodal and gshare instances driven in lockstep,
// checked against a table-level reference model plus directed expectations.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pcF = '0;
   logic        stallF = 1'b0;
   logic        upd_enD = 1'b0;
   logic [31:0] upd_pcD = '0;
   logic        upd_takenD = 1'b0;
   logic [31:0] upd_targetD = '0;
   logic        upd_pred_takenD = 1'b0;
   logic [31:0] upd_pred_targetD = '0;
   logic [7:0]  upd_ghrD = '0;

   logic        b_pt, g_pt, b_mis, g_mis;
   logic [31:0] b_tg, g_tg, b_rd, g_rd;
   logic [7:0]  b_gh, g_gh;

   int checks = 0;
   int failures = 0;

   // reference model state, index 0 = bimodal, 1 = gshare
   int unsigned m_pht  [2][1024];
   bit          m_bv   [2][64];
   int unsigned m_btag [2][64];
   int unsigned m_btgt [2][64];
   int unsigned m_ghr  [2];

   always #5 clk = ~clk;

   branch_predictor #(.MODE(0)) u_bim (
      .clk(clk), .rst(rst), .pcF(pcF), .stallF(stallF),
      .pred_takenF(b_pt), .pred_targetF(b_tg), .ghr_snapF(b_gh),
      .upd_enD(upd_enD), .upd_pcD(upd_pcD), .upd_takenD(upd_takenD),
      .upd_targetD(upd_targetD), .upd_pred_takenD(upd_pred_takenD),
      .upd_pred_targetD(upd_pred_targetD), .upd_ghrD(upd_ghrD),
      .mispredictD(b_mis), .redirect_pcD(b_rd));

   branch_predictor #(.MODE(1)) u_gsh (
      .clk(clk), .rst(rst), .pcF(pcF), .stallF(stallF),
      .pred_takenF(g_pt), .pred_targetF(g_tg), .ghr_snapF(g_gh),
      .upd_enD(upd_enD), .upd_pcD(upd_pcD), .upd_takenD(upd_takenD),
      .upd_targetD(upd_targetD), .upd_pred_takenD(upd_pred_takenD),
      .upd_pred_targetD(upd_pred_targetD), .upd_ghrD(upd_ghrD),
      .mispredictD(g_mis), .redirect_pcD(g_rd));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 1024; i++) m_pht[m][i] = 1;
         for (int i = 0; i < 64; i++) begin
            m_bv[m][i] = 1'b0; m_btag[m][i] = 0; m_btgt[m][i] = 0;
         end
         m_ghr[m] = 0;
      end
   endtask

   task automatic model_predict(input int m, input logic [31:0] pc,
                                output bit hit, output bit tk, output logic [31:0] tg);
      int unsigned pi, bi;
      pi  = ((pc / 4) % 1024) ^ ((m == 1) ? m_ghr[m] : 0);
      bi  = (pc / 4) % 64;
      hit = m_bv[m][bi] && (m_btag[m][bi] == pc / 256);
      tk  = hit && (m_pht[m][pi] >= 2);
      tg  = tk ? m_btgt[m][bi] : pc + 32'd4;
   endtask

   function automatic bit model_mis();
      return upd_enD && ((upd_pred_takenD != upd_takenD) ||
                         (upd_takenD && (upd_pred_targetD != upd_targetD)));
   endfunction

   // compare both instances against the model, then advance the model
   task automatic check_and_advance();
      bit hit, tk, mis;
      logic [31:0] tg, rd;
      int unsigned ui, bi;
      mis = model_mis();
      rd  = upd_takenD ? upd_targetD : upd_pcD + 32'd4;
      for (int m = 0; m < 2; m++) begin
         model_predict(m, pcF, hit, tk, tg);
         chk(m ? "g_taken" : "b_taken", 32'(m ? g_pt : b_pt), 32'(tk));
         chk(m ? "g_target" : "b_target", m ? g_tg : b_tg, tg);
         chk(m ? "g_ghr" : "b_ghr", 32'(m ? g_gh : b_gh), m_ghr[m]);
         chk(m ? "g_mis" : "b_mis", 32'(m ? g_mis : b_mis), 32'(mis));
         chk(m ? "g_redirect" : "b_redirect", m ? g_rd : b_rd, rd);
         if (mis) m_ghr[m] = ((upd_ghrD * 2) + upd_takenD) % 256;
         else if (!stallF && hit) m_ghr[m] = ((m_ghr[m] * 2) + tk) % 256;
         if (upd_enD) begin
            ui = ((upd_pcD / 4) % 1024) ^ ((m == 1) ? 32'(upd_ghrD) : 0);
            bi = (upd_pcD / 4) % 64;
            if (upd_takenD) begin
               if (m_pht[m][ui] < 3) m_pht[m][ui]++;
               m_bv[m][bi] = 1'b1;
               m_btag[m][bi] = upd_pcD / 256;
               m_btgt[m][bi] = upd_targetD;
            end else if (m_pht[m][ui] > 0) begin
               m_pht[m][ui]--;
            end
         end
      end
   endtask

   // one clock: check at the falling edge, then land 1 ns after the rising edge
   task automatic step();
      @(negedge clk);
      check_and_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input bit en, input logic [31:0] pc, input bit t,
                          input logic [31:0] tgt, input bit pt,
                          input logic [31:0] ptgt, input logic [7:0] g);
      upd_enD = en; upd_pcD = pc; upd_takenD = t; upd_targetD = tgt;
      upd_pred_takenD = pt; upd_pred_targetD = ptgt; upd_ghrD = g;
   endtask

   function automatic logic [31:0] pick_pc();
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r == 0) return 32'hFFFF_FFFC;
      if (r < 4)  return 32'h0000_0140 + 32'($urandom_range(0, 7)) * 4;
      return 32'h0000_0040 + 32'($urandom_range(0, 15)) * 4;
   endfunction

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      // reset defaults across a PC sweep
      chk("reset_ghr", 32'(g_gh), 32'h0);
      for (int pc = 0; pc <= 32'h100; pc += 4) begin
         pcF = 32'(pc);
         step();
      end
      pcF = 32'hFFFF_FFFC;
      #1;
      chk("wrap_target", b_tg, 32'h0);
      step();

      // train and saturate at 0x40 -> 0x80
      pcF = 32'h40; stallF = 1'b1;
      set_upd(1, 32'h40, 1, 32'h80, 0, 32'h44, 8'h00);
      step();
      chk("train_first_taken", 32'(b_pt), 32'h1);
      chk("train_first_target", b_tg, 32'h80);
      repeat (3) step();
      set_upd(1, 32'h40, 0, 32'h80, 1, 32'h80, 8'h00);
      repeat (3) step();
      chk("untrain_taken", 32'(b_pt), 32'h0);
      chk("untrain_target", b_tg, 32'h44);

      // retrain, then mispredict with fetch hit in the same cycle
      set_upd(1, 32'h40, 1, 32'h80, 0, 32'h44, 8'h00);
      repeat (2) step();
      chk("retrain_taken", 32'(b_pt), 32'h1);
      stallF = 1'b0;
      set_upd(1, 32'h40, 0, 32'h80, 1, 32'h80, 8'h5A);
      #1;
      chk("recover_mis", 32'(b_mis), 32'h1);
      chk("recover_redirect", b_rd, 32'h44);
      step();
      chk("recover_ghr_bim", 32'(b_gh), 32'hB4);
      chk("recover_ghr_gsh", 32'(g_gh), 32'hB4);

      // target mismatch
      stallF = 1'b1;
      set_upd(1, 32'h40, 1, 32'h90, 1, 32'h80, 8'h00);
      #1;
      chk("tgt_mis", 32'(b_mis), 32'h1);
      chk("tgt_redirect", b_rd, 32'h90);
      step();
      chk("tgt_btb", b_tg, 32'h90);

      // same-cycle read sees the pre-update counter
      set_upd(1, 32'h40, 0, 32'h90, 1, 32'h90, 8'h00);
      #1;
      chk("rw_old", 32'(b_pt), 32'h1);
      step();
      chk("rw_new", 32'(b_pt), 32'h0);

      // reset asserted mid-update: asynchronous, and the update is discarded
      set_upd(1, 32'h40, 1, 32'h80, 0, 32'h44, 8'h00);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_taken", 32'(b_pt), 32'h0);
      chk("arst_target", b_tg, 32'h44);
      chk("arst_ghr", 32'(g_gh), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      set_upd(0, 32'h40, 0, 32'h0, 0, 32'h0, 8'h00);
      step();

      // gshare: same PC, two histories, opposite predictions
      set_upd(1, 32'h40, 1, 32'h80, 0, 32'h44, 8'h00);
      repeat (2) step();
      set_upd(1, 32'h40, 0, 32'h80, 0, 32'h44, 8'h01);
      repeat (2) step();
      set_upd(1, 32'h1000, 0, 32'h2000, 1, 32'h2000, 8'h00);
      step();
      chk("gshare_ghr0", 32'(g_gh), 32'h0);
      chk("gshare_ghr0_taken", 32'(g_pt), 32'h1);
      set_upd(1, 32'h1000, 1, 32'h2000, 0, 32'h1004, 8'h00);
      step();
      chk("gshare_ghr1", 32'(g_gh), 32'h1);
      chk("gshare_ghr1_taken", 32'(g_pt), 32'h0);

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         pcF    = pick_pc();
         stallF = ($urandom_range(0, 3) == 0);
         set_upd($urandom_range(0, 1) == 1, pick_pc(), $urandom_range(0, 1) == 1,
                 32'h100 + 32'($urandom_range(0, 3)) * 16, $urandom_range(0, 1) == 1,
                 32'h100 + 32'($urandom_range(0, 3)) * 16, 8'($urandom_range(0, 255)));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
